// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the debug trace transmitter: record layout,
// FSM state encoding and header byte bit positions.
package cv32e40x_pkg;

  typedef logic [4:0] rf_addr_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        is_compressed;
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic        illegal_insn;
  } dbg_trace_rec_t;

  typedef enum logic [1:0] {
    TRACE_IDLE    = 2'd0,
    TRACE_HDR     = 2'd1,
    TRACE_PAYLOAD = 2'd2
  } dbg_trace_state_e;

  localparam int unsigned TRACE_HDR_ILLEGAL_BIT    = 7;
  localparam int unsigned TRACE_HDR_COMPRESSED_BIT = 6;
  localparam int unsigned TRACE_HDR_RF_WE_BIT      = 5;
  localparam int unsigned TRACE_HDR_WADDR_LSB      = 0;

  function automatic logic [7:0] trace_hdr(dbg_trace_rec_t rec);
    logic [7:0] h;
    h = '0;
    h[TRACE_HDR_ILLEGAL_BIT]          = rec.illegal_insn;
    h[TRACE_HDR_COMPRESSED_BIT]       = rec.is_compressed;
    h[TRACE_HDR_RF_WE_BIT]            = rec.rf_we;
    h[TRACE_HDR_WADDR_LSB +: 5]       = rec.rf_waddr;
    return h;
  endfunction

endpackage

// File: rtl/cv32e40x_dbg_trace_tx_if.sv
// Retired-instruction input and byte-stream output of the trace transmitter.
// Byte stream: a byte transfers on a cycle with tx_valid_o=1 and tx_ready_i=1;
// once tx_valid_o rises, data/last hold and valid stays high until that transfer.
interface cv32e40x_dbg_trace_tx_if;
  import cv32e40x_pkg::*;

  logic        trace_valid_i;
  logic [31:0] instr_i;
  logic        is_compressed_i;
  logic        rf_we_i;
  rf_addr_t    rf_waddr_i;
  logic        illegal_insn_i;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;

  modport master (
    output trace_valid_i, instr_i, is_compressed_i, rf_we_i, rf_waddr_i,
           illegal_insn_i, tx_ready_i,
    input  tx_valid_o, tx_data_o, tx_last_o
  );

  modport slave (
    input  trace_valid_i, instr_i, is_compressed_i, rf_we_i, rf_waddr_i,
           illegal_insn_i, tx_ready_i,
    output tx_valid_o, tx_data_o, tx_last_o
  );

endinterface

// File: rtl/cv32e40x_dbg_trace_fifo.sv
// Record FIFO for the trace transmitter; extra pointer bit tells full from empty.
module cv32e40x_dbg_trace_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  dbg_trace_rec_t             wdata,
  input  logic                       pop,
  output dbg_trace_rec_t             rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  dbg_trace_rec_t mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Push while full is only issued alongside a pop, so overwriting the head
  // slot is safe: the head is read out combinationally before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/cv32e40x_dbg_trace_tx.sv
// Debug trace transmitter: queues retired-instruction records and serializes
// each as a header byte followed by 2 or 4 instruction bytes, LSB first.
module cv32e40x_dbg_trace_tx
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  cv32e40x_dbg_trace_tx_if.slave trace_if,
  output logic                   overflow_o,
  output logic [7:0]             drop_cnt_o,
  output dbg_trace_state_e       dbg_state_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  dbg_trace_state_e state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  dbg_trace_rec_t   in_rec, head;
  logic             full, empty, more;
  logic [CW-1:0]    fifo_count;
  logic             tx_valid, tx_last, hs, pop, push, drop;
  logic [7:0]       tx_data;

  assign in_rec.instr         = trace_if.instr_i;
  assign in_rec.is_compressed = trace_if.is_compressed_i;
  assign in_rec.rf_we         = trace_if.rf_we_i;
  assign in_rec.rf_waddr      = trace_if.rf_waddr_i;
  assign in_rec.illegal_insn  = trace_if.illegal_insn_i;

  assign tx_valid = (state_q != TRACE_IDLE);
  assign hs       = tx_valid && trace_if.tx_ready_i;
  assign pop      = hs && tx_last;
  // A slot freed by this cycle's final byte may be refilled in the same cycle.
  assign push     = trace_if.trace_valid_i && !clear_i && (!full || pop);
  assign drop     = trace_if.trace_valid_i && !clear_i && full && !pop;
  assign more     = fifo_count > CW'(1);

  cv32e40x_dbg_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .push  (push),
    .wdata (in_rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    tx_data = '0;
    tx_last = 1'b0;
    case (state_q)
      TRACE_HDR:     tx_data = trace_hdr(head);
      TRACE_PAYLOAD: begin
        tx_data = head.instr[{idx_q, 3'b000} +: 8];
        tx_last = head.is_compressed ? (idx_q == 2'd1) : (idx_q == 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear_i) begin
      state_d = TRACE_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        TRACE_IDLE: if (push || !empty) state_d = TRACE_HDR;
        TRACE_HDR: if (hs) begin
          state_d = TRACE_PAYLOAD;
          idx_d   = '0;
        end
        TRACE_PAYLOAD: if (hs) begin
          if (tx_last) state_d = (more || push) ? TRACE_HDR : TRACE_IDLE;
          else         idx_d   = idx_q + 2'd1;
        end
        default: state_d = TRACE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRACE_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

  assign trace_if.tx_valid_o = tx_valid;
  assign trace_if.tx_data_o  = tx_data;
  assign trace_if.tx_last_o  = tx_last;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_cv32e40x_dbg_trace_tx.sv
// Bench for cv32e40x_dbg_trace_tx: record-level model (occupancy + expected
// byte queue) checked every cycle, plus literal byte sequences for known records.
module tb_cv32e40x_dbg_trace_tx;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             overflow;
  logic [7:0]       drop_cnt;
  dbg_trace_state_e dbg_state;

  cv32e40x_dbg_trace_tx_if tif ();

  cv32e40x_dbg_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .trace_if    (tif),
    .overflow_o  (overflow),
    .drop_cnt_o  (drop_cnt),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: each entry is {last, data}
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         m_cnt;
  int         m_drop;
  bit         m_ovf;
  bit         prev_stall;
  logic [8:0] prev_byte;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push();
    int n;
    n = tif.is_compressed_i ? 2 : 4;
    exp_q.push_back({1'b0, tif.illegal_insn_i, tif.is_compressed_i, tif.rf_we_i, tif.rf_waddr_i});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tif.instr_i[8*i +: 8]});
  endtask

  // compare process: outputs are checked mid-cycle, then the model advances
  always @(negedge clk) begin
    bit hs, pop;
    if (rst) begin
      chk("rst_valid", {31'd0, tif.tx_valid_o}, 0);
      chk("rst_data", {24'd0, tif.tx_data_o}, 0);
      chk("rst_last", {31'd0, tif.tx_last_o}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, TRACE_IDLE});
      exp_q.delete();
      m_cnt = 0; m_drop = 0; m_ovf = 0; prev_stall = 0;
    end else begin
      chk("valid", {31'd0, tif.tx_valid_o}, {31'd0, (m_cnt > 0)});
      if (tif.tx_valid_o && exp_q.size() > 0)
        chk("byte", {23'd0, tif.tx_last_o, tif.tx_data_o}, {23'd0, exp_q[0]});
      if (prev_stall)
        chk("stall_hold", {22'd0, tif.tx_valid_o, tif.tx_last_o, tif.tx_data_o}, {22'd0, 1'b1, prev_byte});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("drop_cnt", {24'd0, drop_cnt}, m_drop);

      hs  = tif.tx_valid_o && tif.tx_ready_i;
      pop = hs && exp_q.size() > 0 && exp_q[0][8];
      if (hs) got_q.push_back({tif.tx_last_o, tif.tx_data_o});
      prev_stall = tif.tx_valid_o && !tif.tx_ready_i && !clear;
      prev_byte  = {tif.tx_last_o, tif.tx_data_o};
      if (clear) begin
        exp_q.delete();
        m_cnt = 0; m_drop = 0; m_ovf = 0;
      end else begin
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        if (pop) m_cnt--;
        if (tif.trace_valid_i) begin
          if (m_cnt < DEPTH) begin
            model_push();
            m_cnt++;
          end else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input bit c, input bit we,
                       input logic [4:0] wa, input bit ill);
    tif.trace_valid_i   = v;
    tif.instr_i         = instr;
    tif.is_compressed_i = c;
    tif.rf_we_i         = we;
    tif.rf_waddr_i      = wa;
    tif.illegal_insn_i  = ill;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 5'd0, 0);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    idle();
    tif.tx_ready_i = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (m_cnt == 0 && exp_q.size() == 0) done = 1;
    end
    chk({name, "_drain"}, {31'd0, done}, 1);
  endtask

  task automatic chk_seq(input string name, input logic [8:0] lit[], input int n);
    chk({name, "_len"}, got_q.size(), n);
    if (got_q.size() == n)
      for (int i = 0; i < n; i++) chk({name, "_lit"}, {23'd0, got_q[i]}, {23'd0, lit[i]});
  endtask

  initial begin
    logic [8:0] lit[];
    bit found;

    idle();
    tif.tx_ready_i = 0;
    rst = 1;
    repeat (3) step();
    rst = 0;

    // single full-size record, header on the cycle after the push
    got_q.delete();
    tif.tx_ready_i = 1;
    drive(1, 32'h00A00093, 0, 1, 5'd1, 0);
    step();
    idle();
    chk("t1_latency", {22'd0, tif.tx_valid_o, tif.tx_last_o, tif.tx_data_o}, 32'h021 | 32'h200);
    drain("t1");
    lit = '{9'h021, 9'h093, 9'h000, 9'h0A0, 9'h100};
    chk_seq("t1", lit, 5);

    // compressed record
    got_q.delete();
    drive(1, 32'h00004501, 1, 1, 5'd10, 0);
    step();
    drain("t2");
    lit = '{9'h06A, 9'h001, 9'h145};
    chk_seq("t2", lit, 3);

    // six pushes into a stalled sink: four kept, two dropped
    got_q.delete();
    tif.tx_ready_i = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom, 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0);
      step();
    end
    idle();
    step();
    chk("t3_drop_cnt", {24'd0, drop_cnt}, 2);
    chk("t3_overflow", {31'd0, overflow}, 1);
    drain("t3");
    chk("t3_bytes", got_q.size(), 20);
    clear = 1;
    step();
    clear = 0;
    chk("t3_clr_drop", {24'd0, drop_cnt}, 0);
    chk("t3_clr_ovf", {31'd0, overflow}, 0);

    // alternating ready during one record
    got_q.delete();
    tif.tx_ready_i = 0;
    drive(1, 32'hDEADBEEF, 0, 0, 5'd0, 1);
    step();
    idle();
    for (int i = 0; i < 12; i++) begin
      tif.tx_ready_i = (i % 2 == 0);
      step();
    end
    drain("t4");
    lit = '{9'h080, 9'h0EF, 9'h0BE, 9'h0AD, 9'h1DE};
    chk_seq("t4", lit, 5);

    // full FIFO, new push lands on the cycle of a final byte
    got_q.delete();
    tif.tx_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom, 0, 1, 5'(i + 3), 0);
      step();
    end
    idle();
    tif.tx_ready_i = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tif.tx_valid_o && tif.tx_last_o) begin
        drive(1, 32'h12345678, 0, 0, 5'd7, 0);
        found = 1;
      end
    end
    chk("t5_found_last", {31'd0, found}, 1);
    step();
    idle();
    chk("t5_drop_cnt", {24'd0, drop_cnt}, 0);
    drain("t5");
    chk("t5_bytes", got_q.size(), 25);

    // clear on the second byte with two records queued behind
    tif.tx_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 0, 1, 5'(i), 0);
      step();
    end
    idle();
    tif.tx_ready_i = 1;
    step();
    step();
    chk("t6_second_byte_valid", {31'd0, tif.tx_valid_o}, 1);
    clear = 1;
    drive(1, 32'hFFFFFFFF, 0, 1, 5'd31, 1);
    step();
    clear = 0;
    idle();
    chk("t6_valid_after_clear", {31'd0, tif.tx_valid_o}, 0);
    chk("t6_drop_after_clear", {24'd0, drop_cnt}, 0);
    got_q.delete();
    drive(1, 32'h00004501, 1, 1, 5'd10, 0);
    step();
    idle();
    chk("t6_restart_hdr", {22'd0, tif.tx_valid_o, tif.tx_last_o, tif.tx_data_o}, 32'h26A);
    drain("t6");
    lit = '{9'h06A, 9'h001, 9'h145};
    chk_seq("t6", lit, 3);

    // reset mid-record: nothing resumes
    drive(1, 32'hCAFEF00D, 0, 1, 5'd5, 0);
    step();
    idle();
    step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t7_no_resume", {31'd0, tif.tx_valid_o}, 0);
    end

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      tif.tx_ready_i = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 63) == 0);
      step();
    end
    clear = 0;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
